// File: rtl/arcade_input_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_input_pkg : PS/2 scan codes, joystick bit map, coin FSM states |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package arcade_input_pkg;

    localparam logic [7:0] KEY_UP  = 8'h75;
    localparam logic [7:0] KEY_DN  = 8'h72;
    localparam logic [7:0] KEY_LT  = 8'h6B;
    localparam logic [7:0] KEY_RT  = 8'h74;
    localparam logic [7:0] KEY_SPC = 8'h29;
    localparam logic [7:0] KEY_CTL = 8'h14;
    localparam logic [7:0] KEY_F1  = 8'h05;
    localparam logic [7:0] KEY_F2  = 8'h06;
    localparam logic [7:0] BRK     = 8'hF0;
    localparam logic [7:0] EXT     = 8'hE0;

    localparam int JOY_R  = 0;
    localparam int JOY_L  = 1;
    localparam int JOY_D  = 2;
    localparam int JOY_U  = 3;
    localparam int JOY_F  = 4;
    localparam int JOY_S1 = 5;
    localparam int JOY_S2 = 6;
    localparam int JOY_W  = 7;

    // Bit positions of the held-key vector produced by the PS/2 decoder
    localparam int KI_UP   = 0;
    localparam int KI_DN   = 1;
    localparam int KI_LT   = 2;
    localparam int KI_RT   = 3;
    localparam int KI_FIRE = 4;
    localparam int KI_S1   = 5;
    localparam int KI_S2   = 6;
    localparam int KEY_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COIN  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } coin_st_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_decode : toggle-strobe event detect and held key registers   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ps2_key_decode
    import arcade_input_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [64:0]      ps2_key_i,
    output logic [KEY_W-1:0] keys_o
);

    logic             toggle_q;
    logic [KEY_W-1:0] keys_q;
    logic [KEY_W-1:0] keys_d;
    logic             event_w;
    logic             pressed_w;
    logic             ext_w;

    // Unreset on purpose: tracking the strobe through reset means a stale
    // toggle level is never mistaken for a fresh event after release.
    always_ff @(posedge clk_i) begin
        toggle_q <= ps2_key_i[64];
    end

    always_comb begin
        event_w   = (ps2_key_i[64] != toggle_q) && (ps2_key_i[63:24] == '0);
        pressed_w = (ps2_key_i[15:8] != BRK);
        ext_w     = (ps2_key_i[15:8] == EXT) || (ps2_key_i[23:16] == EXT);
        keys_d    = keys_q;
        if (event_w) begin
            case (ps2_key_i[7:0])
                KEY_UP:           keys_d[KI_UP] = pressed_w;
                KEY_DN:           keys_d[KI_DN] = pressed_w;
                KEY_LT:           keys_d[KI_LT] = pressed_w;
                KEY_RT:           keys_d[KI_RT] = pressed_w;
                KEY_SPC, KEY_CTL: if (!ext_w) keys_d[KI_FIRE] = pressed_w;
                KEY_F1:           if (!ext_w) keys_d[KI_S1] = pressed_w;
                KEY_F2:           if (!ext_w) keys_d[KI_S2] = pressed_w;
                default:          keys_d = keys_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keys_q <= '0;
        end else begin
            keys_q <= keys_d;
        end
    end

    assign keys_o = keys_q;

endmodule
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_input_ctrl : key/joystick merge, rotation remap, coin sequencer|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_LEN  = 2400000,
    parameter int GAP_LEN   = 2400000,
    parameter int START_LEN = 2400000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        rotate,
    output logic [7:0]  in0_n,
    output logic [7:0]  in1_n,
    output logic        busy
);

    localparam int CNT_MAX = max3(COIN_LEN, GAP_LEN, START_LEN);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);

    logic [KEY_W-1:0] keys_w;
    logic [JOY_W-1:0] j_w;
    logic             up_w, dn_w, lt_w, rt_w, fire_w;
    logic             s1_w, s2_w, s1_rise_w, s2_rise_w, req_w;
    logic             unused_w;

    coin_st_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             which_s2_q;
    logic             s1_q, s2_q;
    logic [7:0]       in0_n_q, in1_n_q;
    logic             busy_q;

    ps2_key_decode u_ps2_key_decode (
        .clk_i     (clk_sys),
        .rst_ni    (RESET_N),
        .ps2_key_i (ps2_key),
        .keys_o    (keys_w)
    );

    assign unused_w = ^{joy0[15:JOY_W], joy1[15:JOY_W]};

    // On a horizontal display the stick is turned a quarter turn, so each
    // physical direction drives its rotated neighbour.
    always_comb begin
        j_w = joy0[JOY_W-1:0] | joy1[JOY_W-1:0];
        if (rotate) begin
            up_w = keys_w[KI_LT] | j_w[JOY_L];
            dn_w = keys_w[KI_RT] | j_w[JOY_R];
            lt_w = keys_w[KI_DN] | j_w[JOY_D];
            rt_w = keys_w[KI_UP] | j_w[JOY_U];
        end else begin
            up_w = keys_w[KI_UP] | j_w[JOY_U];
            dn_w = keys_w[KI_DN] | j_w[JOY_D];
            lt_w = keys_w[KI_LT] | j_w[JOY_L];
            rt_w = keys_w[KI_RT] | j_w[JOY_R];
        end
        fire_w    = keys_w[KI_FIRE] | j_w[JOY_F];
        s1_w      = keys_w[KI_S1] | j_w[JOY_S1];
        s2_w      = keys_w[KI_S2] | j_w[JOY_S2];
        s1_rise_w = s1_w & ~s1_q;
        s2_rise_w = s2_w & ~s2_q;
        req_w     = which_s2_q ? s2_w : s1_w;
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            which_s2_q <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            in0_n_q    <= 8'hFF;
            in1_n_q    <= 8'hFF;
            busy_q     <= 1'b0;
        end else begin
            s1_q    <= s1_w;
            s2_q    <= s2_w;
            in0_n_q <= ~{2'b00, state_q == COIN, 1'b0, dn_w, rt_w, lt_w, up_w};
            in1_n_q <= ~{1'b0, (state_q == START) && which_s2_q,
                         (state_q == START) && !which_s2_q, fire_w, 4'b0000};
            busy_q  <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (s1_rise_w || s2_rise_w) begin
                        which_s2_q <= !s1_rise_w;
                        state_q    <= COIN;
                        cnt_q      <= '0;
                    end
                end
                COIN: begin
                    if (cnt_q == COIN_LAST) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                START: begin
                    // Start stays asserted while the player keeps holding it.
                    if ((cnt_q >= START_LAST) && !req_w) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q < START_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign in0_n = in0_n_q;
    assign in1_n = in1_n_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arcade_input_ctrl : directed + random bench with behavioural model |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_arcade_input_ctrl;

    localparam int C_LEN = 8;
    localparam int G_LEN = 8;
    localparam int S_LEN = 8;

    localparam int F_UP = 0, F_DN = 1, F_LT = 2, F_RT = 3, F_FIRE = 4, F_S1 = 5, F_S2 = 6;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b1;
    logic [64:0] ps2_key = {1'b1, 64'd0};
    logic [15:0] joy0 = '0;
    logic [15:0] joy1 = '0;
    logic        rotate = 1'b0;
    logic [7:0]  in0_n, in1_n;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    arcade_input_ctrl #(
        .COIN_LEN  (C_LEN),
        .GAP_LEN   (G_LEN),
        .START_LEN (S_LEN)
    ) dut (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .ps2_key (ps2_key),
        .joy0    (joy0),
        .joy1    (joy1),
        .rotate  (rotate),
        .in0_n   (in0_n),
        .in1_n   (in1_n),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    int fmap [512];         // {ext,code} -> key function, -1 = not a game key

    bit        m_tog;
    bit [6:0]  m_keys;
    bit        m_active;
    int        m_elapsed;   // cycles since the sequence began
    int        m_which;
    bit        m_s1p, m_s2p;
    logic [7:0] exp0, exp1;
    logic       exp_busy;

    initial begin
        for (int i = 0; i < 512; i++) fmap[i] = -1;
        for (int e = 0; e < 2; e++) begin
            fmap[e*256 + 'h75] = F_UP;
            fmap[e*256 + 'h72] = F_DN;
            fmap[e*256 + 'h6B] = F_LT;
            fmap[e*256 + 'h74] = F_RT;
        end
        fmap['h029] = F_FIRE;
        fmap['h014] = F_FIRE;
        fmap['h005] = F_S1;
        fmap['h006] = F_S2;
    end

    function automatic bit [6:0] next_keys(bit [6:0] k, logic [64:0] p, bit tog);
        bit [6:0] r = k;
        int code;
        if ((p[64] != tog) && (p[63:24] == '0)) begin
            code = int'(p[7:0]);
            if ((p[15:8] == 8'hE0) || (p[23:16] == 8'hE0)) code += 256;
            if (fmap[code] >= 0) r[fmap[code]] = (p[15:8] != 8'hF0);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_in0(bit [6:0] k, logic [15:0] j, logic rot, bit coin);
        bit u, d, l, r, ou, od, ol, orr;
        u = k[F_UP] | j[3];
        d = k[F_DN] | j[2];
        l = k[F_LT] | j[1];
        r = k[F_RT] | j[0];
        if (rot) begin ou = l; od = r; ol = d; orr = u; end
        else     begin ou = u; od = d; ol = l; orr = r; end
        return 8'hFF - (ou ? 8'h01 : 8'h00) - (ol ? 8'h02 : 8'h00)
                     - (orr ? 8'h04 : 8'h00) - (od ? 8'h08 : 8'h00) - (coin ? 8'h20 : 8'h00);
    endfunction

    function automatic logic [7:0] f_in1(bit [6:0] k, logic [15:0] j, bit st1, bit st2);
        bit fire;
        fire = k[F_FIRE] | j[4];
        return 8'hFF - (fire ? 8'h10 : 8'h00) - (st1 ? 8'h20 : 8'h00) - (st2 ? 8'h40 : 8'h00);
    endfunction

    function automatic bit req(bit [6:0] k, logic [15:0] j, int which);
        return (which == 2) ? (k[F_S2] | j[6]) : (k[F_S1] | j[5]);
    endfunction

    always @(posedge clk_sys) m_tog <= ps2_key[64];

    always @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            m_keys    <= '0;
            m_active  <= 1'b0;
            m_elapsed <= 0;
            m_which   <= 1;
            m_s1p     <= 1'b0;
            m_s2p     <= 1'b0;
            exp0      <= 8'hFF;
            exp1      <= 8'hFF;
            exp_busy  <= 1'b0;
        end else begin
            exp0     <= f_in0(m_keys, joy0 | joy1, rotate, m_active && (m_elapsed < C_LEN));
            exp1     <= f_in1(m_keys, joy0 | joy1,
                              m_active && (m_elapsed >= C_LEN + G_LEN) && (m_which == 1),
                              m_active && (m_elapsed >= C_LEN + G_LEN) && (m_which == 2));
            exp_busy <= m_active;
            m_keys   <= next_keys(m_keys, ps2_key, m_tog);
            m_s1p    <= req(m_keys, joy0 | joy1, 1);
            m_s2p    <= req(m_keys, joy0 | joy1, 2);
            if (!m_active) begin
                if (req(m_keys, joy0 | joy1, 1) && !m_s1p) begin
                    m_active <= 1'b1; m_elapsed <= 0; m_which <= 1;
                end else if (req(m_keys, joy0 | joy1, 2) && !m_s2p) begin
                    m_active <= 1'b1; m_elapsed <= 0; m_which <= 2;
                end
            end else if ((m_elapsed >= C_LEN + G_LEN + S_LEN - 1) && !req(m_keys, joy0 | joy1, m_which)) begin
                m_active <= 1'b0;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_assert++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req_v, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("model_in0_n", {24'd0, in0_n}, {24'd0, exp0});
            check("model_in1_n", {24'd0, in1_n}, {24'd0, exp1});
            check("model_busy",  {31'd0, busy},  {31'd0, exp_busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic send_key(input bit ext, input bit brk, input logic [7:0] code, input bit junk);
        logic [64:0] k;
        k       = '0;
        k[64]   = ~ps2_key[64];
        k[7:0]  = code;
        if (brk) k[15:8] = 8'hF0;
        if (ext) begin
            if (brk) k[23:16] = 8'hE0;
            else     k[15:8]  = 8'hE0;
        end
        if (junk) k[24 + $urandom_range(39)] = 1'b1;
        ps2_key = k;
    endtask

    initial begin
        int c1, c2, cc, first_start, last_coin, idx;
        logic [7:0] code;

        // 1: reset with the strobe already high
        #1 RESET_N = 1'b0;
        chk_en = 1'b1;
        repeat (4) step();
        RESET_N = 1'b1;
        repeat (3) step();
        check("reset_in0_n", {24'd0, in0_n}, 32'hFF);
        check("reset_in1_n", {24'd0, in1_n}, 32'hFF);
        check("reset_busy",  {31'd0, busy},  32'd0);

        // 2: up arrow make / break
        send_key(1'b0, 1'b0, 8'h75, 1'b0);
        step();
        check("up_lat1", {24'd0, in0_n}, 32'hFF);
        step();
        check("up_make", {24'd0, in0_n}, 32'hFE);
        send_key(1'b0, 1'b1, 8'h75, 1'b0);
        step(); step();
        check("up_break", {24'd0, in0_n}, 32'hFF);

        // 3: rotation remap of joystick up
        rotate = 1'b1; joy0[3] = 1'b1;
        step();
        check("rot_up_is_right", {24'd0, in0_n}, 32'hFB);
        rotate = 1'b0;
        step();
        check("norot_up", {24'd0, in0_n}, 32'hFE);
        joy0 = '0;
        step();

        // 4: one-cycle F1 press gives coin, gap, start1
        send_key(1'b0, 1'b0, 8'h05, 1'b0);
        step();
        send_key(1'b0, 1'b1, 8'h05, 1'b0);
        cc = 0; c1 = 0; last_coin = 0; first_start = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!in0_n[5]) begin cc++; last_coin = i; end
            if (!in1_n[5]) begin c1++; if (first_start < 0) first_start = i; end
        end
        check("f1_coin_cycles",  cc, 8);
        check("f1_start_cycles", c1, 8);
        check("f1_gap_cycles",   first_start - last_coin - 1, 8);
        check("f1_busy_end",     {31'd0, busy}, 32'd0);

        // 5: held start2 extends start; an s1 edge during the gap is ignored
        joy1[6] = 1'b1;
        c1 = 0; c2 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!in1_n[5]) c1++;
            if (!in1_n[6]) c2++;
            if (i == 12) joy0[5] = 1'b1;
            if (i == 13) joy0[5] = 1'b0;
            if (i == 30) joy1[6] = 1'b0;
        end
        check("s2_hold_cycles",  c2, 14);
        check("s2_gap_s1_ignored", c1, 0);

        // 6: async reset during START, then simultaneous s1/s2 edges
        joy0[5] = 1'b1;
        repeat (22) step();
        check("pre_reset_start1", {31'd0, in1_n[5]}, 32'd0);
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst_in1_n", {24'd0, in1_n}, 32'hFF);
        check("async_rst_busy",  {31'd0, busy},  32'd0);
        joy0 = '0;
        step(); step();
        RESET_N = 1'b1;
        step(); step();
        joy0[5] = 1'b1; joy1[6] = 1'b1;
        step();
        joy0[5] = 1'b0; joy1[6] = 1'b0;
        c1 = 0; c2 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!in1_n[5]) c1++;
            if (!in1_n[6]) c2++;
        end
        check("both_edge_start1", c1, 8);
        check("both_edge_start2", c2, 0);

        // random traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(8))
                    0: code = 8'h75;
                    1: code = 8'h72;
                    2: code = 8'h6B;
                    3: code = 8'h74;
                    4: code = 8'h29;
                    5: code = 8'h14;
                    6: code = 8'h05;
                    7: code = 8'h06;
                    default: code = 8'($urandom);
                endcase
                send_key($urandom_range(3) == 0, $urandom_range(1) == 1, code,
                         $urandom_range(15) == 0);
            end else if ($urandom_range(7) == 0) begin
                ps2_key[15:0] = 16'($urandom);
            end
            if ($urandom_range(11) == 0) begin
                idx = $urandom_range(6);
                joy0[idx] = ~joy0[idx];
            end
            if ($urandom_range(11) == 0) begin
                idx = $urandom_range(6);
                joy1[idx] = ~joy1[idx];
            end
            if ($urandom_range(31) == 0) joy0[15:7] = 9'($urandom);
            if ($urandom_range(63) == 0) rotate = ~rotate;
            if ($urandom_range(499) == 0) begin
                #2 RESET_N = 1'b0;
                step();
                RESET_N = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
